// File: rtl/pc_ctrl_pkg.sv
// Shared constants and operation encoding for the program-flow controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pc_ctrl_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    // Resolved operation after strobe priority; shared with the decoder.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_JZ   = 3'd1,
        OP_JMP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

    // ret > call > jmp > jz; lower strobes are dropped.
    function automatic op_e resolve_op(input logic ret, input logic call,
                                       input logic jmp, input logic jz);
        if (ret)       return OP_RET;
        else if (call) return OP_CALL;
        else if (jmp)  return OP_JMP;
        else if (jz)   return OP_JZ;
        else           return OP_NONE;
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Decoder/PC-side bundle for pc_ctrl: strobes, target and pc feedback in, load request and RAS status out.
// Latency: ld/addr combinational from inputs; depth/ovf/unf registered.
// Backpressure: none; every strobe is resolved in the cycle it is presented.
interface pc_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int SPW   = 3
);
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] target;
    logic             jmp;
    logic             jz;
    logic             zero;
    logic             call;
    logic             ret;
    logic             ld;
    logic [WIDTH-1:0] addr;
    logic [SPW-1:0]   depth;
    logic             ovf;
    logic             unf;

    // master: decoder / datapath side driving the controller
    modport master (
        output pc_in, target, jmp, jz, zero, call, ret,
        input  ld, addr, depth, ovf, unf
    );

    // slave: the controller itself
    modport slave (
        input  pc_in, target, jmp, jz, zero, call, ret,
        output ld, addr, depth, ovf, unf
    );
endinterface

// File: rtl/pc_ctrl_ras_stack.sv
// Return-address LIFO: push stores din at depth, pop discards top; top reads 0 when empty.
// Latency: top/full/empty combinational from state; push/pop take effect on the next edge.
// Backpressure: push when full and pop when empty are ignored (caller flags them).
// Ports: clk, rst (async high), push, pop, din, top, depth, full, empty.
module ras_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   depth,
    output logic             full,
    output logic             empty
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [IW-1:0]    top_idx;

    assign full    = (sp == SP_FULL);
    assign empty   = (sp == '0);
    assign depth   = sp;
    assign top_idx = IW'(sp - SP_ONE);
    // Gate on empty so a stale entry never leaks out after the stack drains.
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[sp[IW-1:0]] <= din;
            sp              <= sp + SP_ONE;
        end else if (pop && !empty) begin
            sp <= sp - SP_ONE;
        end
    end
endmodule

// File: rtl/pc_ctrl.sv
// Program-flow controller: resolves ret/call/jmp/jz into a pc load request and manages the RAS.
// Latency: ld/addr 0 cycles (combinational); RAS, depth and sticky ovf/unf update on the next edge.
// Backpressure: none; call on full RAS or ret on empty RAS is suppressed (ld=0) and flagged.
// Ports: clk, rst (async high), bus (pc_ctrl_if.slave).
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pc_ctrl_if.slave    bus
);
    localparam int SPW = $clog2(DEPTH) + 1;

    op_e              op;
    logic             push;
    logic             pop;
    logic             ld_c;
    logic [WIDTH-1:0] addr_c;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] ret_addr;
    logic             ras_full;
    logic             ras_empty;
    logic             ovf_q;
    logic             unf_q;

    assign op       = resolve_op(bus.ret, bus.call, bus.jmp, bus.jz);
    // Wraps modulo 2^WIDTH, so a call at the last address returns to 0.
    assign ret_addr = bus.pc_in + WIDTH'(1);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .top   (ras_top),
        .depth (bus.depth),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        ld_c   = 1'b0;
        addr_c = '0;
        push   = 1'b0;
        pop    = 1'b0;
        case (op)
            OP_RET: begin
                if (!ras_empty) begin
                    ld_c   = 1'b1;
                    addr_c = ras_top;
                    pop    = 1'b1;
                end
            end
            OP_CALL: begin
                if (!ras_full) begin
                    ld_c   = 1'b1;
                    addr_c = bus.target;
                    push   = 1'b1;
                end
            end
            OP_JMP: begin
                ld_c   = 1'b1;
                addr_c = bus.target;
            end
            OP_JZ: begin
                if (bus.zero) begin
                    ld_c   = 1'b1;
                    addr_c = bus.target;
                end
            end
            default: begin
                ld_c   = 1'b0;
                addr_c = '0;
            end
        endcase
    end

    assign bus.ld   = ld_c;
    assign bus.addr = addr_c;

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (op == OP_CALL && ras_full)  ovf_q <= 1'b1;
            if (op == OP_RET  && ras_empty) unf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: reference model (queue-based RAS, sticky flags, pc register) checked every cycle,
// plus directed scenarios with literal expectations.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pc_ctrl;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_ctrl_if #(.WIDTH(W), .SPW(SP)) bus ();

    pc_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    logic [W-1:0] stk [$];
    bit           m_ovf;
    bit           m_unf;
    logic [W-1:0] pc;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Expected load request from the rules, given current strobes and model stack.
    function automatic void model_out(output logic e_ld, output logic [W-1:0] e_addr);
        e_ld   = 1'b0;
        e_addr = '0;
        if (bus.ret) begin
            if (stk.size() > 0) begin
                e_ld   = 1'b1;
                e_addr = stk[stk.size()-1];
            end
        end else if (bus.call) begin
            if (stk.size() < D) begin
                e_ld   = 1'b1;
                e_addr = bus.target;
            end
        end else if (bus.jmp) begin
            e_ld   = 1'b1;
            e_addr = bus.target;
        end else if (bus.jz && bus.zero) begin
            e_ld   = 1'b1;
            e_addr = bus.target;
        end
    endfunction

    task automatic compare_model();
        logic         e_ld;
        logic [W-1:0] e_addr;
        model_out(e_ld, e_addr);
        chk("ld",    32'(bus.ld),    32'(e_ld));
        chk("addr",  32'(bus.addr),  32'(e_addr));
        chk("depth", 32'(bus.depth), 32'(stk.size()));
        chk("ovf",   32'(bus.ovf),   32'(m_ovf));
        chk("unf",   32'(bus.unf),   32'(m_unf));
    endtask

    task automatic apply(input logic j, input logic z_en, input logic z,
                         input logic c, input logic r, input logic [W-1:0] t);
        @(negedge clk);
        bus.pc_in  = pc;
        bus.jmp    = j;
        bus.jz     = z_en;
        bus.zero   = z;
        bus.call   = c;
        bus.ret    = r;
        bus.target = t;
        #1;
        compare_model();
    endtask

    // Advance the model across the rising edge using the inputs held there.
    task automatic edge_update();
        logic         e_ld;
        logic [W-1:0] e_addr;
        @(posedge clk);
        model_out(e_ld, e_addr);
        if (bus.ret) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else                m_unf = 1'b1;
        end else if (bus.call) begin
            if (stk.size() < D) stk.push_back(W'((int'(bus.pc_in) + 1) % 256));
            else                m_ovf = 1'b1;
        end
        pc = e_ld ? e_addr : W'(pc + 1);
    endtask

    task automatic step(input logic j, input logic z_en, input logic z,
                        input logic c, input logic r, input logic [W-1:0] t);
        apply(j, z_en, z, c, r, t);
        edge_update();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        bus.pc_in  = '0;
        bus.target = '0;
        bus.jmp    = 1'b0;
        bus.jz     = 1'b0;
        bus.zero   = 1'b0;
        bus.call   = 1'b0;
        bus.ret    = 1'b0;
        pc         = 8'h00;
        model_reset();

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_ld",    32'(bus.ld), 32'h0);
        chk("idle_addr",  32'(bus.addr), 32'h0);
        chk("idle_depth", 32'(bus.depth), 32'h0);
        chk("idle_flags", {30'h0, bus.ovf, bus.unf}, 32'h0);
        edge_update();

        // jmp
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA7);
        chk("jmp_ld",   32'(bus.ld), 32'h1);
        chk("jmp_addr", 32'(bus.addr), 32'hA7);
        edge_update();
        chk("jmp_pc", 32'(pc), 32'hA7);

        // jz not taken / taken
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
        chk("jz0_ld", 32'(bus.ld), 32'h0);
        chk("jz0_addr", 32'(bus.addr), 32'h0);
        edge_update();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
        chk("jz1_ld", 32'(bus.ld), 32'h1);
        chk("jz1_addr", 32'(bus.addr), 32'h40);
        edge_update();

        // call at 0x10 -> 0x80, then ret to 0x11
        pc = 8'h10;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        chk("call_addr", 32'(bus.addr), 32'h80);
        edge_update();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("call_depth1", 32'(bus.depth), 32'h1);
        chk("ret_addr", 32'(bus.addr), 32'h11);
        edge_update();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ret_depth0", 32'(bus.depth), 32'h0);
        edge_update();

        // call at 0xFF wraps to 0x00
        pc = 8'hFF;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap_ret_ld", 32'(bus.ld), 32'h1);
        chk("wrap_ret_addr", 32'(bus.addr), 32'h00);
        edge_update();

        // Overflow: four pushes then a fifth call
        for (int i = 0; i < 4; i++) begin
            pc = W'(8'h30 + i);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(8'h90 + i));
        end
        pc = 8'h3F;
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        chk("ovf_call_ld", 32'(bus.ld), 32'h0);
        edge_update();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_flag", 32'(bus.ovf), 32'h1);
        chk("ovf_depth", 32'(bus.depth), 32'h4);
        edge_update();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            chk("lifo_addr", 32'(bus.addr), 32'(8'h34 - i));
            edge_update();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_ret_ld", 32'(bus.ld), 32'h0);
        chk("unf_ret_addr", 32'(bus.addr), 32'h0);
        edge_update();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("unf_flag", 32'(bus.unf), 32'h1);
        chk("unf_depth", 32'(bus.depth), 32'h0);
        edge_update();

        // Async reset at depth 3 with both flags set
        for (int i = 0; i < 3; i++) begin
            pc = W'(8'h50 + i);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
        end
        @(negedge clk);
        bus.call = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_depth", 32'(bus.depth), 32'h0);
        chk("arst_ovf", 32'(bus.ovf), 32'h0);
        chk("arst_unf", 32'(bus.unf), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ret+call+jmp together, depth 1 with top 0x22
        pc = 8'h21;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        chk("prio_ld", 32'(bus.ld), 32'h1);
        chk("prio_addr", 32'(bus.addr), 32'h22);
        edge_update();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("prio_depth", 32'(bus.depth), 32'h0);
        edge_update();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic r, c, j, z_en, z;
            r    = ($urandom_range(0, 99) < 22);
            c    = ($urandom_range(0, 99) < 28);
            j    = ($urandom_range(0, 99) < 12);
            z_en = ($urandom_range(0, 99) < 20);
            z    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 9) == 0) pc = W'($urandom);
            step(j, z_en, z, c, r, W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
